// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch stage with a prefetch FIFO, credit-based
//               memory issue and branch-redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable_fetch,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      mem_enable,
    output logic                      mem_rw,
    output logic [1:0]                mem_access_size,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    input  logic                      mem_busy,
    input  logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic                      insn_valid,
    output logic [DATA_WIDTH-1:0]     insn,
    output logic [ADDR_WIDTH-1:0]     insn_pc,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int                    c_ptr_w  = $clog2(DEPTH);
    localparam logic [c_ptr_w+1:0]    c_depth  = (c_ptr_w+2)'(DEPTH);
    localparam logic [c_ptr_w-1:0]    c_ptr_1  = c_ptr_w'(1);
    localparam logic [ADDR_WIDTH-1:0] c_step   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_start  = {START_ADDR[ADDR_WIDTH-1:2], 2'b00};

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic                  r_inflight;
    logic                  r_drop;
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w:0]      r_count;

    logic [c_ptr_w+1:0]    w_pending;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused_bits;

    // Slots already promised to an in-flight response count against issue.
    assign w_pending  = {1'b0, r_count} + {{(c_ptr_w+1){1'b0}}, r_inflight};
    assign mem_enable = reset_n & enable_fetch & ~redirect_valid & (w_pending < c_depth);
    assign w_accept   = mem_enable & ~mem_busy;
    assign w_push     = r_inflight & ~r_drop;
    assign w_pop      = insn_valid & ~stall;

    assign mem_rw          = 1'b1;
    assign mem_access_size = 2'b00;
    assign mem_address     = r_fetch_pc;

    assign insn_valid = (r_count != '0);
    assign insn       = r_data[r_rd_ptr];
    assign insn_pc    = r_pc[r_rd_ptr];
    assign level      = r_count;

    assign w_unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_fetch_pc    <= c_start;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_drop        <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // Flush wins over everything; the response landing now is lost with the FIFO.
            r_fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_drop     <= r_inflight;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_drop <= 1'b0;
            if (w_accept) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + c_step;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_push) begin
                r_data[r_wr_ptr] <= mem_data_out;
                r_pc[r_wr_ptr]   <= r_inflight_pc;
                r_wr_ptr         <= r_wr_ptr + c_ptr_1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_1;
            end
            r_count <= r_count + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: cycle table, directed
//               corner sequences and an in-order fetch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] c_s = 32'h80020000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable_fetch;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_address;
    logic        mem_busy;
    logic [31:0] mem_data_out = '0;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        en;
        logic        st;
        logic        bz;
        logic        rd;
        logic [31:0] rpc;
        logic        me;
        logic [31:0] addr;
        logic        v;
        logic [2:0]  lvl;
        logic [31:0] ipc;
    } vec_t;
    vec_t tbl [15];

    fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .START_ADDR (32'h80020000)
    ) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable_fetch    (enable_fetch),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_enable      (mem_enable),
        .mem_rw          (mem_rw),
        .mem_access_size (mem_access_size),
        .mem_address     (mem_address),
        .mem_busy        (mem_busy),
        .mem_data_out    (mem_data_out),
        .insn_valid      (insn_valid),
        .insn            (insn),
        .insn_pc         (insn_pc),
        .level           (level)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5AF00D;
    endfunction

    // Memory model: one-cycle read latency after acceptance.
    always @(posedge clock) begin
        if (mem_enable && !mem_busy) mem_data_out <= mem_word(mem_address);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted requests queue up, popped instructions must match in order.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n || redirect_valid) begin
            exp_q.delete();
        end else begin
            if (insn_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pc", insn_pc, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", insn_pc, e.pc);
                    chk("sb_insn", insn, e.data);
                end
            end
            if (mem_enable && !mem_busy) begin
                e.pc   = mem_address;
                e.data = mem_word(mem_address);
                exp_q.push_back(e);
            end
        end
    end

    task automatic drive(input logic en, input logic st, input logic bz,
                         input logic rd, input logic [31:0] rpc);
        enable_fetch   = en;
        stall          = st;
        mem_busy       = bz;
        redirect_valid = rd;
        redirect_pc    = rpc;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, c_s,         1'b0, 3'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, c_s + 32'h4, 1'b0, 3'd0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, c_s + 32'h8, 1'b1, 3'd1, c_s};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, c_s + 32'hC, 1'b1, 3'd1, c_s + 32'h4};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, c_s + 32'h10, 1'b1, 3'd2, c_s + 32'h4};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, c_s + 32'h14, 1'b1, 3'd3, c_s + 32'h4};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, c_s + 32'h14, 1'b1, 3'd4, c_s + 32'h4};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, c_s + 32'h14, 1'b1, 3'd4, c_s + 32'h4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, c_s + 32'h14, 1'b1, 3'd3, c_s + 32'h8};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, c_s + 32'h18, 1'b1, 3'd2, c_s + 32'hC};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, c_s + 32'h18, 1'b1, 3'd2, c_s + 32'h10};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, c_s + 32'h18, 1'b1, 3'd1, c_s + 32'h14};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, c_s + 32'h18, 1'b0, 3'd0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h80020103, 1'b0, c_s + 32'h18, 1'b0, 3'd0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80020100, 1'b0, 3'd0, 32'h0};

        // Reset, with fetch enabled to show requests stay masked.
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
        chk("rst_insn_valid", {31'h0, insn_valid}, 32'h0);
        chk("rst_level", {29'h0, level}, 32'h0);
        chk("rst_insn", insn, 32'h0);
        chk("rst_insn_pc", insn_pc, 32'h0);
        chk("mem_rw", {31'h0, mem_rw}, 32'h1);
        chk("mem_access_size", {30'h0, mem_access_size}, 32'h0);
        next_cycle();
        reset_n = 1'b1;

        // Cycle table: streaming, stall fill, busy hold, enable off, redirect.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].en, tbl[i].st, tbl[i].bz, tbl[i].rd, tbl[i].rpc);
            @(negedge clock);
            chk($sformatf("tbl%0d_mem_enable", i), {31'h0, mem_enable}, {31'h0, tbl[i].me});
            chk($sformatf("tbl%0d_mem_address", i), mem_address, tbl[i].addr);
            chk($sformatf("tbl%0d_insn_valid", i), {31'h0, insn_valid}, {31'h0, tbl[i].v});
            chk($sformatf("tbl%0d_level", i), {29'h0, level}, {29'h0, tbl[i].lvl});
            if (tbl[i].v) chk($sformatf("tbl%0d_insn_pc", i), insn_pc, tbl[i].ipc);
            next_cycle();
        end

        // Redirect with a request in flight (0x80020100 accepted last cycle).
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80020203);
        @(negedge clock);
        chk("redir_no_issue", {31'h0, mem_enable}, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("redir_r1_valid", {31'h0, insn_valid}, 32'h0);
        chk("redir_r1_level", {29'h0, level}, 32'h0);
        chk("redir_r1_enable", {31'h0, mem_enable}, 32'h1);
        chk("redir_r1_addr", mem_address, 32'h80020200);
        next_cycle();
        @(negedge clock);
        chk("redir_r2_valid", {31'h0, insn_valid}, 32'h0);
        next_cycle();
        @(negedge clock);
        chk("redir_r3_valid", {31'h0, insn_valid}, 32'h1);
        chk("redir_r3_pc", insn_pc, 32'h80020200);
        chk("redir_r3_insn", insn, mem_word(32'h80020200));
        next_cycle();
        repeat (4) next_cycle();

        // Address wrap at the top of the address space.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("wrap_addr_top", mem_address, 32'hFFFFFFFC);
        next_cycle();
        @(negedge clock);
        chk("wrap_addr_zero", mem_address, 32'h00000000);
        next_cycle();
        repeat (4) next_cycle();

        // Stall held 10 cycles after a redirect: FIFO saturates, head holds.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80020300);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c >= 3) begin
                chk($sformatf("stall%0d_pc", c), insn_pc, 32'h80020300);
                chk($sformatf("stall%0d_insn", c), insn, mem_word(32'h80020300));
            end
            if (c >= 6) begin
                chk($sformatf("stall%0d_level", c), {29'h0, level}, 32'h4);
                chk($sformatf("stall%0d_enable", c), {31'h0, mem_enable}, 32'h0);
            end
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            chk($sformatf("release%0d_valid", c), {31'h0, insn_valid}, 32'h1);
            next_cycle();
        end

        // Reset for one cycle while the FIFO is full.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (6) next_cycle();
        @(negedge clock);
        chk("prerst_level", {29'h0, level}, 32'h4);
        next_cycle();
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_enable", {31'h0, mem_enable}, 32'h0);
        next_cycle();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("postrst_level", {29'h0, level}, 32'h0);
        chk("postrst_valid", {31'h0, insn_valid}, 32'h0);
        chk("postrst_enable", {31'h0, mem_enable}, 32'h1);
        chk("postrst_addr", mem_address, 32'h80020000);
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk("postrst_first_pc", insn_pc, 32'h80020000);
        chk("postrst_first_valid", {31'h0, insn_valid}, 32'h1);
        next_cycle();
        repeat (6) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with an internal prefetch FIFO, sitting between the unified memory model and the decode stage. It issues one-word read requests to memory on a busy handshake and buffers up to DEPTH returned instructions with their PCs. It presents the buffered instructions to decode under a stall backpressure signal, and supports a branch redirect that flushes the buffer and discards any in-flight response.

## Interface
- ADDR_WIDTH, 32, PC / memory address width
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- START_ADDR, 32'h80020000, PC loaded at reset (bits [1:0] forced to 0)
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable_fetch  in  1  1 = fetch unit may issue memory requests
- stall  in  1  1 = decode cannot accept this cycle
- redirect_valid  in  1  1 = load new PC and flush
- redirect_pc  in  ADDR_WIDTH  redirect target (bits [1:0] ignored)
- mem_enable  out  1  read request this cycle
- mem_rw  out  1  constant 1 (read)
- mem_access_size  out  2  constant 2'b00 (one word)
- mem_address  out  ADDR_WIDTH  request address = fetch_pc
- mem_busy  in  1  memory cannot accept a request this cycle
- mem_data_out  in  DATA_WIDTH  read data, valid the cycle after acceptance
- insn_valid  out  1  FIFO head holds a valid instruction
- insn  out  DATA_WIDTH  FIFO head instruction
- insn_pc  out  ADDR_WIDTH  PC of insn
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State: fetch_pc, inflight flag, inflight_pc, drop flag, FIFO (data+PC), rd/wr pointers, count.
- Issue (combinational): mem_enable = enable_fetch & ~redirect_valid & (count + inflight < DEPTH). Accepted when mem_enable & ~mem_busy.
- On accept: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (modulo 2^ADDR_WIDTH, wraps to 0).
- Response: in the cycle after accept, mem_data_out is pushed with inflight_pc unless drop = 1; inflight clears unless a new request is accepted in the same cycle (back-to-back allowed, max one in flight).
- Pop: when insn_valid & ~stall, the head advances; push and pop in the same cycle leave count unchanged.
- Credit rule guarantees no overflow: a response always has a reserved slot; pop in the current cycle is not credited to issue.
- Redirect (highest priority): FIFO cleared (count = 0, pointers = 0), fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}, no request issued that cycle, drop <= inflight (a response arriving next cycle is discarded). drop clears after the discarded response.
- enable_fetch low: no new requests; the in-flight response is still captured; popping continues.
- Reset (reset_n = 0 at edge): fetch_pc = START_ADDR, inflight = 0, drop = 0, count = 0, insn_valid = 0, insn = 0, insn_pc = 0, level = 0; mem_enable low throughout reset.

## Timing
- Request accepted cycle N → pushed at edge ending cycle N+1 → insn_valid high cycle N+2 (latency 2).
- Sustained throughput: 1 instruction/cycle with mem_busy = 0 and stall = 0.
- insn/insn_pc/insn_valid are registered FIFO-head outputs; they hold stable while stall = 1.
- mem_busy high: request holds address; fetch_pc does not advance.
- Full FIFO (count = DEPTH): mem_enable low; it reasserts the cycle after a pop.
- Redirect in cycle R: insn_valid low in cycle R+1; the first new request is in R+1; the first new instruction is valid in R+3.
- Reset asserted mid-operation: the in-flight response is ignored; state returns to reset values on the next edge.

## Test plan
- Reset then enable_fetch = 1 with memory preloaded at 0x80020000..: mem_address 0x80020000, 0x80020004, ... in consecutive cycles; insn_pc 0x80020000 valid 2 cycles after the first request; in-order words.
- stall = 1 held 10 cycles, DEPTH = 4: level saturates at 4, mem_enable low, insn/insn_pc unchanged; release → 4 pops then streaming resumes without gaps or loss.
- mem_busy high for 3 cycles on request 0x80020008: address held, no duplicate/missing PC in the output stream.
- redirect_valid with redirect_pc = 0x80020103 while a request is in flight: FIFO emptied, stale response dropped, next insn_pc = 0x80020100.
- fetch_pc = 0xFFFFFFFC: next request address is 0x00000000.
- reset_n low for 1 cycle mid-stream with a full FIFO: next cycle level = 0, insn_valid = 0, and the first request after release is at 0x80020000.
